// File: rtl/seq_entrada_pkg.sv
// Shared types for the RPN calculator input sequencer: FSM state encodings
// (also driven onto the LEDs) and the default debounce length.
package seq_entrada_pkg;

  typedef enum logic [1:0] {
    ESPERA_A  = 2'b00,
    ESPERA_B  = 2'b01,
    ESPERA_OP = 2'b10,
    EXECUTA   = 2'b11
  } estado_t;

  // 20 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_PADRAO = 1000000;

endpackage

// File: rtl/debounce_botao.sv
// Entry button conditioning: two-flop synchronizer, stability counter and a
// registered one-cycle press event (falling edge of the stable level).
module debounce_botao #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic botao_n_i,
  output logic pulso_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

  logic          sinc1_q, sinc2_q;
  logic          estavel_q, estavel_d;
  logic          pulso_q, pulso_d;
  logic [CW-1:0] cont_q, cont_d;

  // The level is accepted on the cycle the count would reach DEBOUNCE_CYCLES,
  // and the press event is registered on that same edge.
  always_comb begin
    estavel_d = estavel_q;
    cont_d    = '0;
    pulso_d   = 1'b0;
    if (sinc2_q != estavel_q) begin
      if (cont_q == TERMINAL) begin
        estavel_d = sinc2_q;
        pulso_d   = ~sinc2_q;
      end else begin
        cont_d = cont_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sinc1_q   <= 1'b1;
      sinc2_q   <= 1'b1;
      estavel_q <= 1'b1;
      cont_q    <= '0;
      pulso_q   <= 1'b0;
    end else begin
      sinc1_q   <= botao_n_i;
      sinc2_q   <= sinc1_q;
      estavel_q <= estavel_d;
      cont_q    <= cont_d;
      pulso_q   <= pulso_d;
    end
  end

  assign pulso_o = pulso_q;

endmodule

// File: rtl/sequenciador_entrada.sv
// RPN calculator input sequencer: captures A, B and op from the switch bus on
// debounced presses and hands the triple downstream over valid/ready.
// Build option SEQ_ENTRADA_ENCADEAR_EN: adds resultado_in and reloads A from it
// on each handshake, resuming at ESPERA_B.
//
// state     | meaning
// ESPERA_A  | waiting for press to capture operand A
// ESPERA_B  | waiting for press to capture operand B
// ESPERA_OP | waiting for press to capture operation code
// EXECUTA   | triple valid, waiting for downstream ready
module sequenciador_entrada
  import seq_entrada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_PADRAO,
  parameter int WIDTH           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             botao_n,
  input  logic [WIDTH-1:0] sw,
`ifdef SEQ_ENTRADA_ENCADEAR_EN
  input  logic [WIDTH-1:0] resultado_in,
`endif
  output logic [WIDTH-1:0] operando_a,
  output logic [WIDTH-1:0] operando_b,
  output logic [WIDTH-1:0] codigo_op,
  output logic             saida_valida,
  input  logic             saida_pronta,
  output logic [1:0]       estado,
  output logic             pulso_botao
);

  estado_t          estado_q;
  logic [WIDTH-1:0] op_a_q, op_b_q, cod_q;
  logic             valida_q;
  logic             pulso;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .botao_n_i(botao_n),
    .pulso_o  (pulso)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      estado_q <= ESPERA_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      cod_q    <= '0;
      valida_q <= 1'b0;
    end else begin
      case (estado_q)
        ESPERA_A: if (pulso) begin
          op_a_q   <= sw;
          estado_q <= ESPERA_B;
        end
        ESPERA_B: if (pulso) begin
          op_b_q   <= sw;
          estado_q <= ESPERA_OP;
        end
        ESPERA_OP: if (pulso) begin
          cod_q    <= sw;
          valida_q <= 1'b1;
          estado_q <= EXECUTA;
        end
        // presses here are dropped on purpose
        EXECUTA: if (valida_q && saida_pronta) begin
          valida_q <= 1'b0;
`ifdef SEQ_ENTRADA_ENCADEAR_EN
          op_a_q   <= resultado_in;
          estado_q <= ESPERA_B;
`else
          estado_q <= ESPERA_A;
`endif
        end
        default: estado_q <= ESPERA_A;
      endcase
    end
  end

  assign operando_a   = op_a_q;
  assign operando_b   = op_b_q;
  assign codigo_op    = cod_q;
  assign saida_valida = valida_q;
  assign estado       = estado_q;
  assign pulso_botao  = pulso;

endmodule

// File: tb/tb_sequenciador_entrada.sv
// Self-checking bench for sequenciador_entrada with DEBOUNCE_CYCLES = 4;
// expected triples are queued at stimulus time and popped on handshake.
module tb_sequenciador_entrada;

  localparam int D = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         botao_n;
  logic [W-1:0] sw;
  logic [W-1:0] resultado_in;
  logic [W-1:0] operando_a, operando_b, codigo_op;
  logic         saida_valida, saida_pronta, pulso_botao;
  logic [1:0]   estado;

  int checks = 0;
  int errors = 0;
  int n_pulsos = 0;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] op;
  } trio_t;
  trio_t fila[$];

  always #5 clk = ~clk;

  sequenciador_entrada #(
    .DEBOUNCE_CYCLES(D),
    .WIDTH          (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .botao_n     (botao_n),
    .sw          (sw),
`ifdef SEQ_ENTRADA_ENCADEAR_EN
    .resultado_in(resultado_in),
`endif
    .operando_a  (operando_a),
    .operando_b  (operando_b),
    .codigo_op   (codigo_op),
    .saida_valida(saida_valida),
    .saida_pronta(saida_pronta),
    .estado      (estado),
    .pulso_botao (pulso_botao)
  );

  always @(negedge clk) if (pulso_botao) n_pulsos++;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obtido=%0h esperado=%0h", tag, obs, exp);
    end
  endtask

  // Drives a clean press; checks press latency (2 sync + D) and pulse width.
  task automatic pressiona(input logic [W-1:0] v);
    int lat;
    bit ok;
    ok  = 1'b0;
    lat = 0;
    sw      = v;
    botao_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pulso_botao) begin
        ok  = 1'b1;
        lat = i + 1;
        break;
      end
    end
    verifica("pulso_visto", {31'd0, ok}, 32'd1);
    verifica("latencia_pulso", lat, 2 + D);
    @(negedge clk);
    verifica("largura_pulso", {31'd0, pulso_botao}, 32'd0);
    sw      = 8'hFF;
    botao_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic pulso_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic verifica_zero(input string tag);
    verifica({tag, "_a"}, operando_a, 0);
    verifica({tag, "_b"}, operando_b, 0);
    verifica({tag, "_op"}, codigo_op, 0);
    verifica({tag, "_valida"}, {31'd0, saida_valida}, 0);
    verifica({tag, "_estado"}, estado, 0);
    verifica({tag, "_pulso"}, {31'd0, pulso_botao}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog tempo esgotado");
    $fatal(1);
  end

  initial begin
    int   seg;
    int   pulsos_antes;
    trio_t t;

    rst          = 1'b0;
    botao_n      = 1'b1;
    sw           = '0;
    saida_pronta = 1'b0;
    resultado_in = 8'h11;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // idle: ready toggles must be ignored while nothing is valid
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      saida_pronta = 1'($urandom_range(0, 1));
    end
    saida_pronta = 1'b0;
    @(negedge clk);
    verifica_zero("ocioso");
    verifica("ocioso_pulsos", n_pulsos, 0);

    // short glitch
    botao_n = 1'b0;
    repeat (2) @(negedge clk);
    botao_n = 1'b1;
    repeat (12) @(negedge clk);
    verifica("glitch_pulsos", n_pulsos, 0);
    verifica("glitch_estado", estado, 2'b00);

    pressiona(8'h0C);
    verifica("a_captura", operando_a, 8'h0C);
    verifica("a_estado", estado, 2'b01);
    pressiona(8'h05);
    verifica("b_captura", operando_b, 8'h05);
    verifica("b_estado", estado, 2'b10);
    verifica("b_a_estavel", operando_a, 8'h0C);
    fila.push_back('{a: 8'h0C, b: 8'h05, op: 8'h01});
    pressiona(8'h01);
    verifica("op_captura", codigo_op, 8'h01);
    verifica("op_pulsos", n_pulsos, 3);

    seg = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (saida_valida && estado == 2'b11) seg++;
    end
    verifica("valida_mantida", seg, 20);

    // press in EXECUTA is discarded
    pressiona(8'h33);
    verifica("exec_a", operando_a, 8'h0C);
    verifica("exec_b", operando_b, 8'h05);
    verifica("exec_op", codigo_op, 8'h01);
    verifica("exec_estado", estado, 2'b11);
    verifica("exec_valida", {31'd0, saida_valida}, 1);

    @(negedge clk);
    saida_pronta = 1'b1;
    #1;
    if (saida_valida && saida_pronta) begin
      if (fila.size() == 0) begin
        verifica("fila_vazia", 0, 1);
      end else begin
        t = fila.pop_front();
        verifica("sb_a", operando_a, t.a);
        verifica("sb_b", operando_b, t.b);
        verifica("sb_op", codigo_op, t.op);
      end
    end else begin
      verifica("sb_handshake", {31'd0, saida_valida}, 1);
    end
    @(negedge clk);
    saida_pronta = 1'b0;
    verifica("hs_valida", {31'd0, saida_valida}, 0);
`ifdef SEQ_ENTRADA_ENCADEAR_EN
    verifica("hs_estado", estado, 2'b01);
    verifica("hs_a_encadeado", operando_a, 8'h11);
`else
    verifica("hs_estado", estado, 2'b00);
    verifica("hs_a_mantido", operando_a, 8'h0C);
`endif
    verifica("hs_op_mantido", codigo_op, 8'h01);
    verifica("fila_final", fila.size(), 0);

    // reset in ESPERA_OP drops the partial triple
    pulso_reset();
    @(negedge clk);
    verifica_zero("reset1");
    pressiona(8'h0C);
    pressiona(8'h05);
    verifica("pre_reset_estado", estado, 2'b10);
    verifica("pre_reset_a", operando_a, 8'h0C);
    pulsos_antes = n_pulsos;
    pulso_reset();
    verifica_zero("reset2");
    repeat (10) @(negedge clk);
    verifica("pos_reset_pulsos", n_pulsos, pulsos_antes);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequenciador_entrada.md
# sequenciador_entrada

Input-side stage of the RPN calculator. It debounces the raw entry button, turns each clean press into a one-cycle event, and walks the operand A → operand B → operation sequence, capturing the shared 8-bit switch bus at each step. It delivers a complete {A, B, op} triple to the downstream stack/ALU stage over a valid/ready handshake, and exposes its sequence state for the LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a button level change (20 ms at 50 MHz); legal minimum 2.
- `WIDTH`, default 8: operand and operation code width.
- `clk` in 1: system clock (CLOCK_50 domain).
- `rst` in 1: reset; one clock; reset is synchronous and active-low.
- `botao_n` in 1: raw entry button, asynchronous, active-low (KEY[0]).
- `sw` in WIDTH: shared switch bus carrying operand or operation code.
- `operando_a` out WIDTH: captured operand A.
- `operando_b` out WIDTH: captured operand B.
- `codigo_op` out WIDTH: captured raw operation code.
- `saida_valida` out 1: triple complete and held stable.
- `saida_pronta` in 1: downstream accepts the triple.
- `estado` out 2: sequence state (LED indication).
- `pulso_botao` out 1: debounced press event, one cycle.
- `resultado_in` in WIDTH: previous result; present only with SEQ_ENTRADA_ENCADEAR_EN.

## Operation
- Synchronizer: two flops on `botao_n`, both reset to 1 (button released).
- Debounce: counter increments each cycle that the synchronized level differs from the stable level, and clears when they match. On the cycle it would reach DEBOUNCE_CYCLES, the stable level takes the synchronized level and the counter clears. Stable level resets to 1.
- `pulso_botao` = stable level 1→0 transition (press). It is high for exactly one cycle. Release generates no event.
- FSM states and `estado` encoding:
  - ESPERA_A = 00: press → `operando_a` ← `sw`, go to ESPERA_B.
  - ESPERA_B = 01: press → `operando_b` ← `sw`, go to ESPERA_OP.
  - ESPERA_OP = 10: press → `codigo_op` ← `sw`, `saida_valida` ← 1, go to EXECUTA.
  - EXECUTA = 11: hold all outputs. On `saida_valida` & `saida_pronta`, `saida_valida` ← 0 and return to ESPERA_A. Presses in this state are discarded, not queued.
- Captured registers change only at their own capture step. They stay stable while `saida_valida` is high and after the handshake.
- Reset values: `operando_a`, `operando_b`, `codigo_op` = 0; `saida_valida` = 0; `estado` = 00; `pulso_botao` = 0; debounce counter = 0.
- Reset mid-sequence or mid-debounce: all state returns to the reset values in the same edge, and a partial triple is lost.
- `sw` is sampled only on press cycles; it is not registered otherwise.

## Timing
- Press latency: button low → `pulso_botao` high after 2 synchronizer cycles + DEBOUNCE_CYCLES.
- Capture: the register update and state advance occur on the edge after the cycle with `pulso_botao` high (1-cycle latency).
- `saida_valida` rises on the same edge that loads `codigo_op`.
- `saida_pronta` already high when `saida_valida` rises: handshake completes on the next edge, so `saida_valida` is high for exactly 1 cycle.
- `saida_pronta` may toggle freely while `saida_valida` = 0; it is ignored then.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.

## Configuration
- `SEQ_ENTRADA_ENCADEAR_EN` defined:
  - `resultado_in` port exists.
  - On the handshake, `operando_a` ← `resultado_in` and the FSM goes to ESPERA_B, chaining results RPN-style.
- Not defined: no `resultado_in` port; the handshake returns the FSM to ESPERA_A and `operando_a` keeps its value until the next capture.

## Structure
- Package `seq_entrada_pkg`: state typedef with the four encodings, and the default DEBOUNCE_CYCLES constant.
- Sub-module `debounce_botao`: synchronizer, counter, stable level and press-event output. The FSM and capture registers stay in the top of this block.

## Test plan
Benches use DEBOUNCE_CYCLES = 4.
- Reset, then hold `botao_n` = 1 for 50 cycles → all outputs 0, `estado` = 00, no `pulso_botao`.
- `botao_n` low for 2 cycles, then high → no `pulso_botao`, `estado` stays 00.
- Three clean presses with `sw` = 0x0C, 0x05, 0x01, `saida_pronta` = 0 → A = 0x0C, B = 0x05, op = 0x01. `saida_valida` = 1 and `estado` = 11, both held for 20 cycles. Raise `saida_pronta` → `saida_valida` falls next edge and `estado` = 00.
- Press with `sw` = 0x33 while in EXECUTA → no register change and no state change.
- Assert `rst` = 0 for one edge while in ESPERA_OP with A = 0x0C → all outputs reset, `estado` = 00.
- With SEQ_ENTRADA_ENCADEAR_EN and `resultado_in` = 0x11, complete a handshake → `operando_a` = 0x11, `estado` = 01.
